// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Desc     : Shared state type and default constants for the frequency meter.
// Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

   localparam int CLK_HZ_DEF = 50_000_000;
   localparam int CNT_W_DEF  = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } fm_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_rise_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_rise_det
// Desc     : Two-flop synchronizer with one-cycle rising-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sync_rise_det
   import freq_meter_pkg::*;
(
   input  logic mclk,
   input  logic reset,
   input  logic d_async,
   input  logic load_prev,
   output logic q_sync,
   output logic rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge mclk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= d_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   // While load_prev is high the history is being re-seeded, so no edge is reported.
   assign q_sync = r_sync;
   assign rise   = r_sync & ~r_prev & ~load_prev;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Desc     : Counts rising edges of a slow async input over a fixed gate window.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEF,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int GATE_W      = 32
) (
   input  logic             mclk,
   input  logic             reset,
   input  logic             Enable,
   input  logic             sig_in,
   output logic [CNT_W-1:0] freq,
   output logic             freq_valid,
   output logic             overflow,
   output logic             busy
);

   localparam logic [GATE_W-1:0] c_gate_last = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  c_cnt_max   = '1;

   fm_state_t         r_state;
   fm_state_t         w_next;
   logic [GATE_W-1:0] r_gate_cnt;
   logic [CNT_W-1:0]  r_edge_cnt;
   logic              r_sat;
   logic [CNT_W-1:0]  r_freq;
   logic              r_overflow;
   logic              r_freq_valid;

   logic              w_rise;
   logic              w_load_prev;
   logic              w_busy;
   logic              w_last;
   logic [CNT_W-1:0]  w_edge_next;
   logic              w_sat_next;
   logic              w_unused_sync;

   sync_rise_det u_sync (
      .mclk      (mclk),
      .reset     (reset),
      .d_async   (sig_in),
      .load_prev (w_load_prev),
      .q_sync    (w_unused_sync),
      .rise      (w_rise)
   );

   assign w_last = (r_gate_cnt == c_gate_last);

   // Saturating edge count: a rise arriving at full scale sets sat instead of wrapping.
   always_comb begin
      w_edge_next = r_edge_cnt;
      w_sat_next  = r_sat;
      if (w_rise) begin
         if (r_edge_cnt == c_cnt_max) begin
            w_sat_next = 1'b1;
         end else begin
            w_edge_next = r_edge_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_busy      = 1'b0;
      w_load_prev = 1'b0;
      case (r_state)
         IDLE: begin
            if (Enable) begin
               w_next = ARM;
            end
         end
         ARM: begin
            w_busy      = 1'b1;
            w_load_prev = 1'b1;
            w_next      = MEASURE;
         end
         MEASURE: begin
            w_busy = 1'b1;
            if (!Enable) begin
               w_next = IDLE;
            end else if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = Enable ? ARM : IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Result and strobe are registered together on the last gate cycle so that
   // freq already holds the new value in the cycle freq_valid is high (DONE).
   always_ff @(posedge mclk) begin
      if (reset) begin
         r_gate_cnt   <= '0;
         r_edge_cnt   <= '0;
         r_sat        <= 1'b0;
         r_freq       <= '0;
         r_overflow   <= 1'b0;
         r_freq_valid <= 1'b0;
      end else begin
         r_freq_valid <= 1'b0;
         case (r_state)
            ARM: begin
               r_gate_cnt <= '0;
               r_edge_cnt <= '0;
               r_sat      <= 1'b0;
            end
            MEASURE: begin
               if (!w_last) begin
                  r_gate_cnt <= r_gate_cnt + GATE_W'(1);
               end
               r_edge_cnt <= w_edge_next;
               r_sat      <= w_sat_next;
               if (Enable && w_last) begin
                  r_freq       <= w_edge_next;
                  r_overflow   <= w_sat_next;
                  r_freq_valid <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign freq       = r_freq;
   assign freq_valid = r_freq_valid;
   assign overflow   = r_overflow;
   assign busy       = w_busy;

   a_single_strobe: assert property (@(posedge mclk) disable iff (reset)
      r_freq_valid |=> !r_freq_valid);

   a_gate_bound: assert property (@(posedge mclk) disable iff (reset)
      r_gate_cnt <= c_gate_last);

endmodule
`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a slow asynchronous square wave by counting its rising edges over a fixed gate window of GATE_CYCLES mclk cycles.
- With defaults the window is 1 s, so the result is in Hz.
- Consumer-side counterpart of the clock-divider outputs: feeds the display path and self-checks on-board divided clocks.
- Result is held in a register and announced by a single-cycle valid strobe.

Parameters:
- CLK_HZ, 50_000_000, mclk frequency in Hz.
- GATE_CYCLES, CLK_HZ, gate window length in mclk cycles (use 100 in simulation).
- CNT_W, 32, width of the edge counter and result.
- GATE_W, 32, width of the gate counter; must hold GATE_CYCLES-1.

Ports:
- mclk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Enable  in  1  high = measure continuously; low = idle or abort.
- sig_in  in  1  asynchronous signal under measurement.
- freq  out  CNT_W  last completed measurement (edges per gate window).
- freq_valid  out  1  one-cycle strobe when freq updates.
- overflow  out  1  edge count saturated in the last completed window; updates with freq.
- busy  out  1  high in ARM and MEASURE.

Behaviour:
- Reset, sampled on the mclk edge:
  - state=IDLE.
  - freq=0, freq_valid=0, overflow=0, busy=0.
  - Sync flops, edge history, gate counter and edge counter all 0.
  - Reset applies in any state; an in-flight window is discarded with no strobe.
- Input conditioning:
  - sig_in passes through a 2-FF synchronizer to give s_sync.
  - rise = s_sync & ~s_prev, where s_prev is s_sync delayed one cycle.
  - Input-to-count latency is 3 mclk cycles.
  - Maximum countable rate is one edge per 2 mclk cycles; faster inputs alias, and this is not flagged.
- State machine (IDLE, ARM, MEASURE, DONE):
  - IDLE: busy=0. Enable=1 -> ARM.
  - ARM, exactly 1 cycle:
    - gate_cnt=0, edge_cnt=0, sat=0.
    - s_prev is loaded with s_sync, so a level already high is not counted.
    - Next state -> MEASURE.
  - MEASURE, exactly GATE_CYCLES cycles:
    - gate_cnt increments each cycle.
    - On each rise, edge_cnt increments.
    - At edge_cnt = 2^CNT_W-1, edge_cnt holds and sat=1.
    - When gate_cnt == GATE_CYCLES-1, a rise in that same cycle is still counted; next state -> DONE.
    - Enable=0 in any MEASURE cycle -> IDLE. No strobe; freq and overflow keep their old values.
  - DONE, 1 cycle:
    - freq <= edge_cnt, overflow <= sat, freq_valid=1 for this cycle only.
    - Enable=1 -> ARM, back-to-back windows with a 2-cycle dead time (DONE plus ARM).
    - Enable=0 -> IDLE.
    - Enable is not checked for abort in DONE; the strobe always completes.
- Timing:
  - Enable rises and is sampled at cycle 0; ARM is cycle 1; MEASURE is cycles 2..GATE_CYCLES+1.
  - freq_valid is high in cycle GATE_CYCLES+2.
  - Continuous mode period is GATE_CYCLES+2 cycles.
- Width rules:
  - Counters are unsigned.
  - The gate compare is an equality compare against the constant GATE_CYCLES-1.
  - No arithmetic wrap is permitted: edge_cnt saturates, and gate_cnt is bounded by the FSM.
- freq_valid is never high for two consecutive cycles.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum type (IDLE, ARM, MEASURE, DONE);
  - default constants CLK_HZ_DEF=50_000_000 and CNT_W_DEF=32.
- Sub-module sync_rise_det:
  - contains the 2-FF synchronizer, edge history and rise pulse;
  - has ports mclk, reset, d_async, load_prev, q_sync, rise.
- FSM and counters stay in freq_meter.

Test Plan:
- Period and continuous mode (GATE_CYCLES=100): Enable held high, sig_in period 10 cycles, 50% duty:
  - freq_valid pulses at cycle 102, then every 102 cycles;
  - freq=10 (±1 depending on phase), overflow=0.
- sig_in held high before and through Enable rise: freq=0. sig_in held low: freq=0, freq_valid still pulses.
- Saturation (CNT_W=4, GATE_CYCLES=100): sig_in period 2 cycles -> freq=15, overflow=1. Next window at period 20 -> freq=5, overflow=0.
- Abort: prior result freq=10; drop Enable at MEASURE cycle 50 -> no freq_valid, freq stays 10, busy=0 next cycle. Re-raise Enable -> fresh full window.
- Reset mid-window: assert reset at MEASURE cycle 30 -> next cycle freq=0, overflow=0, freq_valid=0, busy=0, state IDLE.
- Last-cycle edge: align a single sig_in rise so that rise occurs in the cycle where gate_cnt=GATE_CYCLES-1 -> counted, freq=1.
